// File: rtl/inst_fetch_buf_pkg.sv
// rtl/inst_fetch_buf_pkg.sv - shared constants and types for the instruction fetch buffer
package inst_fetch_buf_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_t ZERO_WORD    = '0;
    localparam logic  CHIP_ENABLE  = 1'b1;
    localparam logic  CHIP_DISABLE = 1'b0;
    localparam logic  STOP         = 1'b1;
    localparam logic  NO_STOP      = 1'b0;

    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_FILL = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_line_buf.sv
// rtl/fetch_line_buf.sv - line storage with one synchronous write port and one asynchronous read port
module fetch_line_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    localparam int W = $clog2(LINE_WORDS)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  inst_t        wdata,
    input  logic [W-1:0] raddr,
    output inst_t        rdata
);

    inst_t mem_q [LINE_WORDS];
    inst_t mem_d [LINE_WORDS];

    // Next contents: copy of the line with the addressed word replaced on a write
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register; contents are meaningless until a fill completes, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - single-line instruction fetch buffer with req/ack line refill
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_i,
    input  inst_addr_t addr_i,
    output inst_t      inst_o,
    output logic       stall_req_o,
    input  logic       inv_i,
    output logic       mem_req_o,
    output inst_addr_t mem_addr_o,
    input  logic       mem_ack_i,
    input  inst_t      mem_rdata_i
);

    localparam int W     = $clog2(LINE_WORDS);
    localparam int TAG_W = INST_ADDR_W - W - 2;
    localparam logic [W-1:0] CNT_LAST = W'(LINE_WORDS - 1);

    fetch_state_e     state_q, state_d;
    logic             valid_q, valid_d;
    logic             inv_seen_q, inv_seen_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
    logic [W-1:0]     cnt_q, cnt_d;

    logic [TAG_W-1:0] addr_tag;
    logic [W-1:0]     addr_word;
    logic             hit;
    logic             miss;
    logic             line_we;
    inst_t            line_rdata;

    // Byte-offset bits of the fetch address carry no information for word fetches
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    assign addr_tag  = addr_i[INST_ADDR_W-1:W+2];
    assign addr_word = addr_i[W+1:2];

    fetch_line_buf #(
        .LINE_WORDS(LINE_WORDS)
    ) u_line (
        .clk  (clk),
        .we   (line_we),
        .waddr(cnt_q),
        .wdata(mem_rdata_i),
        .raddr(addr_word),
        .rdata(line_rdata)
    );

    // Hit/miss detection and the combinational core and memory-side outputs
    always_comb begin
        hit         = (ce_i == CHIP_ENABLE) && valid_q && (addr_tag == tag_q) && (state_q == FETCH_IDLE);
        miss        = (ce_i == CHIP_ENABLE) && !hit && (state_q == FETCH_IDLE);
        inst_o      = hit ? line_rdata : ZERO_WORD;
        stall_req_o = (miss || (state_q == FETCH_FILL)) ? STOP : NO_STOP;
        mem_req_o   = (state_q == FETCH_FILL);
        mem_addr_o  = (state_q == FETCH_FILL) ? {fill_tag_q, cnt_q, 2'b00} : '0;
    end

    // Next-state logic: start a fill on a miss, step through the line on each accepted ack
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        inv_seen_d = inv_seen_q;
        tag_d      = tag_q;
        fill_tag_d = fill_tag_q;
        cnt_d      = cnt_q;
        line_we    = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (inv_i) begin
                    valid_d = 1'b0;
                end
                if (miss) begin
                    fill_tag_d = addr_tag;
                    valid_d    = 1'b0;
                    inv_seen_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = FETCH_FILL;
                end
            end
            FETCH_FILL: begin
                // An invalidate mid-fill must not be lost: the new line would be stale
                if (inv_i) begin
                    inv_seen_d = 1'b1;
                end
                if (mem_ack_i) begin
                    line_we = 1'b1;
                    cnt_d   = cnt_q + W'(1);
                    if (cnt_q == CNT_LAST) begin
                        tag_d   = fill_tag_q;
                        valid_d = !(inv_seen_q || inv_i);
                        state_d = FETCH_IDLE;
                    end
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // Control state registers; reset may land mid-burst and abandons it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            valid_q    <= 1'b0;
            inv_seen_q <= 1'b0;
            tag_q      <= '0;
            fill_tag_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            inv_seen_q <= inv_seen_d;
            tag_q      <= tag_d;
            fill_tag_q <= fill_tag_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb/tb_inst_fetch_buf.sv - randomized self-checking bench for inst_fetch_buf
module tb_inst_fetch_buf;

    localparam int LW = 4;

    logic        clk;
    logic        rst;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic        stall_req_o;
    logic        inv_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int total;
    int bad;

    inst_fetch_buf #(.LINE_WORDS(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .inst_o     (inst_o),
        .stall_req_o(stall_req_o),
        .inv_i      (inv_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, a[31:16] ^ 16'hc3e1} + 32'h0f1e2d3c;
    endfunction

    // Instruction memory behaviour: returns the word at whatever address is requested
    assign mem_rdata_i = mem_data(mem_addr_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: a cached line plus a queue of word addresses still owed by the memory
    logic [31:0] m_line [LW];
    logic        m_valid;
    logic [31:0] m_base;
    logic [31:0] m_fill_base;
    logic        m_inv;
    logic [31:0] m_pending [$];
    logic        last_stall;

    task automatic step(input logic r, input logic c, input logic [31:0] a,
                        input logic iv, input logic ak);
        logic        hit;
        logic [31:0] e_inst;
        logic        e_stall;
        logic [31:0] e_addr;
        logic [31:0] w;
        rst = r; ce_i = c; addr_i = a; inv_i = iv; mem_ack_i = ak;
        #1;
        if (r) begin
            m_pending.delete();
            m_valid = 1'b0;
            m_base  = '0;
        end
        hit     = c && m_valid && (a[31:4] == m_base[31:4]) && (m_pending.size() == 0);
        e_inst  = hit ? m_line[a[3:2]] : 32'h0;
        e_stall = (m_pending.size() != 0) || (c && !hit);
        e_addr  = (m_pending.size() != 0) ? m_pending[0] : 32'h0;
        check("inst", inst_o, e_inst);
        check("stall", {31'b0, stall_req_o}, {31'b0, e_stall});
        check("req", {31'b0, mem_req_o}, {31'b0, m_pending.size() != 0});
        check("maddr", mem_addr_o, e_addr);
        last_stall = stall_req_o;
        if (!r) begin
            if (m_pending.size() == 0) begin
                if (iv) m_valid = 1'b0;
                if (c && !hit) begin
                    m_valid     = 1'b0;
                    m_inv       = 1'b0;
                    m_fill_base = {a[31:4], 4'h0};
                    for (int i = 0; i < LW; i++) m_pending.push_back(m_fill_base + 32'(4 * i));
                end
            end else begin
                if (iv) m_inv = 1'b1;
                if (ak) begin
                    w = m_pending.pop_front();
                    m_line[w[3:2]] = mem_data(w);
                    if (m_pending.size() == 0) begin
                        m_base  = m_fill_base;
                        m_valid = !m_inv;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    int          stalls;
    logic [31:0] ra;
    logic [31:0] bases [4];

    initial begin
        total = 0; bad = 0;
        m_valid = 1'b0; m_base = '0; m_fill_base = '0; m_inv = 1'b0;
        rst = 1'b1; ce_i = 1'b1; addr_i = '0; inv_i = 1'b0; mem_ack_i = 1'b1;
        bases[0] = 32'h0; bases[1] = 32'h100; bases[2] = 32'h200; bases[3] = 32'h300;
        @(negedge clk);

        // reset with fetch enabled, then fill line 0
        step(1, 1, 32'h0, 0, 1);
        check("rst_stall", {31'b0, stall_req_o}, 32'h1);
        for (int i = 0; i < 6; i++) step(0, 1, 32'h0, 0, 1);

        // fill 0x100 line, then zero-stall hits
        for (int i = 0; i < 6; i++) step(0, 1, 32'h100, 0, 1);
        step(0, 1, 32'h104, 0, 1);
        check("hit104", inst_o, mem_data(32'h104));
        step(0, 1, 32'h10c, 0, 0);
        step(0, 1, 32'h100, 0, 1);

        // slow memory: ack every third cycle
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 32'h208, 0, (i % 3) == 0);
            if (last_stall) stalls++;
        end
        check("slow_stall_cycles", stalls, 32'd13);

        // invalidate during the second word of a fill
        stalls = 0;
        for (int i = 0; i < 14; i++) begin
            step(0, 1, 32'h300, i == 2, 1);
            if (last_stall) stalls++;
        end
        check("inv_stall_cycles", stalls, 32'd10);

        // reset after two acks of a burst, then refill from word 0
        for (int i = 0; i < 3; i++) step(0, 1, 32'h404, 0, 1);
        step(1, 1, 32'h404, 0, 1);
        check("rst_mid_req", {31'b0, mem_req_o}, 32'h0);
        for (int i = 0; i < 7; i++) step(0, 1, 32'h404, 0, 1);

        // chip disabled with a valid line and stray acks
        for (int i = 0; i < 4; i++) step(0, 0, 32'h404, 0, 1);
        step(0, 1, 32'h40c, 0, 0);
        check("after_ce0_hit", inst_o, mem_data(32'h40c));

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            ra = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ra = $urandom & 32'h0000fffc;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, ra,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buf.md
# inst_fetch_buf

Single-line instruction fetch buffer between the core's instruction-ROM port (`ce`/addr out, instruction in) and a variable-latency instruction memory with a req/ack handshake. It serves the core combinationally on a hit and raises a stall request on a miss. It then refills one aligned line of LINE_WORDS words from the memory, one word per accepted handshake. It feeds the IF/ID register directly and drives the stall request consumed by the pipeline stall controller.

## Interface
- LINE_WORDS, 4, words per line; power of two, ≥2; line is LINE_WORDS*4 bytes, aligned.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce_i  in  1  core fetch enable (ChipEnable = 1).
- addr_i  in  32  core fetch byte address; bits [1:0] ignored.
- inst_o  out  32  instruction to IF/ID; ZeroWord unless hit.
- stall_req_o  out  1  1 = core must hold PC and IF/ID.
- inv_i  in  1  invalidate the line buffer.
- mem_req_o  out  1  word read request.
- mem_addr_o  out  32  word address of request, bits [1:0] = 0.
- mem_ack_i  in  1  read data valid; counted only while mem_req_o = 1.
- mem_rdata_i  in  32  read data, sampled on the edge where req & ack.

## Operation
- State: line storage LINE_WORDS x 32, tag = addr[31:W+2] (W = log2 LINE_WORDS), valid bit, word counter cnt[W-1:0], FSM {IDLE, FILL}.
- hit = ce_i & valid & (addr_i tag == tag) & state==IDLE.
- inst_o = hit ? line[addr_i[W+1:2]] : ZeroWord (combinational).
- stall_req_o = (state==IDLE & ce_i & ~hit) | (state==FILL) (combinational).
- ce_i = 0: inst_o = ZeroWord, stall_req_o = 0, no fetch.
- IDLE, miss (ce_i & ~hit): latch fill tag from addr_i, clear valid, cnt←0, go FILL.
- FILL: mem_req_o=1, mem_addr_o={fill_tag, cnt, 2'b00}; address and req held stable until ack.
  - On req&ack: line[cnt]←mem_rdata_i, cnt←cnt+1.
  - Ack on the last word (cnt = LINE_WORDS-1): tag←fill_tag, valid←1 unless an invalidate occurred during the fill; go IDLE; cnt wraps to 0.
- Words fill in order 0..LINE_WORDS-1; no critical-word-first.
- inv_i in IDLE: valid←0 at the next edge; a hit in the same cycle is still served.
- inv_i during FILL: the burst completes; valid stays 0 at the end; the core re-misses next cycle and a fresh fill starts.
- addr_i/ce_i changing during FILL (e.g. external core reset): the burst always completes; hit/miss is then re-evaluated in IDLE.
- Reset, asynchronous at any time including mid-burst: state IDLE, valid 0, cnt 0, tag 0, mem_req_o 0, mem_addr_o 0. stall_req_o = ce_i (always a miss), inst_o = ZeroWord. Line contents need no reset.

## Timing
- Hit: zero-cycle latency; inst_o is valid in the same cycle as addr_i.
- Miss with ack tied high: stall_req_o is high for 1 + LINE_WORDS cycles (5 for default), then a hit.
- Each memory wait cycle extends the stall by one cycle; there is no timeout.
- mem_req_o rises the cycle after the miss is detected and falls the cycle after the last ack.
- Ack with req low is ignored.

## Structure
- Shared defines header: ZeroWord, ChipEnable/ChipDisable, InstAddrBus, InstBus, Stop/NoStop, FSM state encodings (FetchIdle, FetchFill).
- Sub-module fetch_line_buf: LINE_WORDS x 32 storage with one sync write port (we, waddr, wdata) and one async read port. The top holds FSM, tag, valid and counter.

## Test plan
- Reset with ce_i=1, addr 0x0 → stall_req_o=1, inst_o=0, mem_req_o=0; after reset release, mem_addr_o=0x0,0x4,0x8,0xC on successive cycles (ack=1); then inst_o=word0, stall 0.
- After filling 0x100-0x10C, addr 0x104/0x10C/0x100 → inst_o = the matching words, zero stall, mem_req_o=0.
- Miss at 0x200 with ack asserted every 3rd cycle → mem_addr_o held stable between acks, stall 1+12 cycles, correct data.
- inv_i pulsed during the second word of the fill at 0x300 → fill ends, next cycle still miss, new fill from 0x300, then hit.
- rst asserted mid-burst (after 2 acks) → mem_req_o=0 immediately, valid=0; after release a refill starts from word 0.
- ce_i=0 with valid line and stray mem_ack_i=1 → inst_o=0, stall 0, no state change.
